// File: rtl/hs_elastic_pipe.sv
// Elastic req/ack buffer: DEPTH-entry circular store between a handshake producer
// and consumer, four-phase or two-phase signalling, optional 2-flop input synchronisers.
module hs_elastic_pipe #(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 4,
  parameter int PHASES      = 4,
  parameter int SYNC_STAGES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  output logic                       ack_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       req_out,
  input  logic                       ack_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH+1);
  localparam bit TWO_PH = (PHASES == 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  logic             w_req_s, w_ack_s;
  logic             w_full, w_wr, w_pop;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ack_in, r_req_out;
  logic [WIDTH-1:0] r_data_out;
  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];

  generate
    if (SYNC_STAGES == 2) begin : g_sync
      logic [1:0] r_req_sync, r_ack_sync;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_req_sync <= '0;
          r_ack_sync <= '0;
        end else begin
          r_req_sync <= {r_req_sync[0], req_in};
          r_ack_sync <= {r_ack_sync[0], ack_out};
        end
      end
      assign w_req_s = r_req_sync[1];
      assign w_ack_s = r_ack_sync[1];
    end else begin : g_nosync
      assign w_req_s = req_in;
      assign w_ack_s = ack_out;
    end
  endgenerate

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A four-phase request still high while ack_in=1 is the tail of the previous transfer.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_wr   = ~w_full & (TWO_PH ? (w_req_s != r_ack_in) : (w_req_s & ~r_ack_in));
  assign w_pop  = (r_state == S_REQ) & (TWO_PH ? (w_ack_s == r_req_out) : w_ack_s);

  // NOTE: storage is deliberately not reset; count and pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ack_in <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= next_ptr(r_wptr);
      if (w_pop) r_rptr <= next_ptr(r_rptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (TWO_PH) begin
        if (w_wr) r_ack_in <= ~r_ack_in;
      end else if (w_wr) begin
        r_ack_in <= 1'b1;
      end else if (r_ack_in && !w_req_s) begin
        r_ack_in <= 1'b0;
      end
    end
  end

  // data_out is loaded only when a new request is issued and held through the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_out  <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_count != '0 && (TWO_PH || !w_ack_s)) begin
          r_state    <= S_REQ;
          r_req_out  <= TWO_PH ? ~r_req_out : 1'b1;
          r_data_out <= r_mem[r_rptr];
        end
        S_REQ: if (w_pop) begin
          r_state <= TWO_PH ? S_IDLE : S_WAIT;
          if (!TWO_PH) r_req_out <= 1'b0;
        end
        S_WAIT: if (!w_ack_s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_in   = r_ack_in;
  assign req_out  = r_req_out;
  assign data_out = r_data_out;
  assign count    = r_count;

endmodule

// File: tb/tb_hs_elastic_pipe.sv
// Directed bench for hs_elastic_pipe: four-phase DEPTH=4, four-phase DEPTH=3 wrap
// streaming, and two-phase with 2-flop synchronisers.
module tb_hs_elastic_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WIDTH=3, DEPTH=4, four-phase, no sync
  logic       a_req, a_ack_in, a_req_out, a_ack_out;
  logic [2:0] a_din, a_dout, a_count;
  // Instance B: WIDTH=4, DEPTH=3, four-phase, no sync
  logic       b_req, b_ack_in, b_req_out, b_ack_out;
  logic [3:0] b_din, b_dout;
  logic [1:0] b_count;
  // Instance C: WIDTH=3, DEPTH=3, two-phase, 2-flop sync
  logic       c_req, c_ack_in, c_req_out, c_ack_out;
  logic [2:0] c_din, c_dout;
  logic [1:0] c_count;

  hs_elastic_pipe #(.WIDTH(3), .DEPTH(4), .PHASES(4), .SYNC_STAGES(0)) u_a (
    .clk(clk), .rst(rst), .req_in(a_req), .ack_in(a_ack_in), .data_in(a_din),
    .req_out(a_req_out), .ack_out(a_ack_out), .data_out(a_dout), .count(a_count));
  hs_elastic_pipe #(.WIDTH(4), .DEPTH(3), .PHASES(4), .SYNC_STAGES(0)) u_b (
    .clk(clk), .rst(rst), .req_in(b_req), .ack_in(b_ack_in), .data_in(b_din),
    .req_out(b_req_out), .ack_out(b_ack_out), .data_out(b_dout), .count(b_count));
  hs_elastic_pipe #(.WIDTH(3), .DEPTH(3), .PHASES(2), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .req_in(c_req), .ack_in(c_ack_in), .data_in(c_din),
    .req_out(c_req_out), .ack_out(c_ack_out), .data_out(c_dout), .count(c_count));

  int n_checks = 0;
  int n_fail   = 0;
  int b_max    = 0;

  typedef struct {
    logic       req;
    logic       ack_o;
    logic [2:0] din;
    logic       e_ack;
    logic       e_req;
    logic [2:0] e_dout;
    logic [2:0] e_cnt;
  } vec_t;
  vec_t vecs[20];

  always @(negedge clk) if (int'(b_count) > b_max) b_max = int'(b_count);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_a(input logic [2:0] d);
    a_din = d;
    a_req = 1'b1;
    for (int k = 0; k < 100 && a_ack_in !== 1'b1; k++) @(posedge clk) #1;
    check("push_a ack rise", a_ack_in, 1);
    a_req = 1'b0;
    for (int k = 0; k < 100 && a_ack_in !== 1'b0; k++) @(posedge clk) #1;
    check("push_a ack fall", a_ack_in, 0);
  endtask

  task automatic pop_a(input logic [2:0] exp);
    for (int k = 0; k < 100 && a_req_out !== 1'b1; k++) @(posedge clk) #1;
    check("pop_a req_out rise", a_req_out, 1);
    check("pop_a data", a_dout, exp);
    a_ack_out = 1'b1;
    for (int k = 0; k < 100 && a_req_out !== 1'b0; k++) @(posedge clk) #1;
    check("pop_a req_out fall", a_req_out, 0);
    a_ack_out = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] d);
    b_din = d;
    b_req = 1'b1;
    for (int k = 0; k < 200 && b_ack_in !== 1'b1; k++) @(posedge clk) #1;
    check("push_b ack rise", b_ack_in, 1);
    b_req = 1'b0;
    for (int k = 0; k < 200 && b_ack_in !== 1'b0; k++) @(posedge clk) #1;
    check("push_b ack fall", b_ack_in, 0);
  endtask

  task automatic pop_b(input logic [3:0] exp);
    for (int k = 0; k < 200 && b_req_out !== 1'b1; k++) @(posedge clk) #1;
    check("pop_b req_out rise", b_req_out, 1);
    check("pop_b data order", b_dout, exp);
    b_ack_out = 1'b1;
    for (int k = 0; k < 200 && b_req_out !== 1'b0; k++) @(posedge clk) #1;
    check("pop_b req_out fall", b_req_out, 0);
    b_ack_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req   ack_o din     e_ack e_req e_dout  e_cnt
    vecs = '{
      '{1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 3'b000, 3'd1},
      '{1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 3'd1},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b101, 3'd1},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b101, 3'd0},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b101, 3'd0},
      '{1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 3'b101, 3'd1},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b110, 3'd1},
      '{1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 3'b110, 3'd2},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b110, 3'd1},
      '{1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 3'b110, 3'd2},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b011, 3'd2},
      '{1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 3'b011, 3'd2},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b011, 3'd2},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b111, 3'd2},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b111, 3'd1},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111, 3'd1},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 3'b001, 3'd1},
      '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 3'd0},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 3'd0},
      '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 3'd0}
    };

    rst = 1'b1;
    a_req = 0; a_ack_out = 0; a_din = '0;
    b_req = 0; b_ack_out = 0; b_din = '0;
    c_req = 0; c_ack_out = 0; c_din = '0;
    @(posedge clk) #1;
    check("reset state A", {a_ack_in, a_req_out, a_dout, a_count}, 0);
    check("reset state C", {c_ack_in, c_req_out, c_dout, c_count}, 0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Cycle-by-cycle vectors: single word, fall-through latency, simultaneous push/pop, wrap
    for (int i = 0; i < 20; i++) begin
      a_req     = vecs[i].req;
      a_ack_out = vecs[i].ack_o;
      a_din     = vecs[i].din;
      @(posedge clk) #1;
      check($sformatf("vec%0d {ack_in,req_out,data_out,count}", i),
            {a_ack_in, a_req_out, a_dout, a_count},
            {vecs[i].e_ack, vecs[i].e_req, vecs[i].e_dout, vecs[i].e_cnt});
    end

    // Fill and stall: four words with no consumer, fifth blocked until one pop
    for (int i = 1; i <= 4; i++) push_a(3'(i));
    check("fill count", a_count, 4);
    a_din = 3'b101;
    a_req = 1'b1;
    repeat (6) @(posedge clk) #1;
    check("full ack_in held low", a_ack_in, 0);
    check("full count", a_count, 4);
    check("full head req_out", a_req_out, 1);
    check("full head data", a_dout, 3'b001);
    a_ack_out = 1'b1;
    @(posedge clk) #1;
    check("pop from full count", a_count, 3);
    check("pop from full ack_in still low", a_ack_in, 0);
    @(posedge clk) #1;
    check("blocked write ack_in rise", a_ack_in, 1);
    check("blocked write count", a_count, 4);
    a_req = 1'b0;
    a_ack_out = 1'b0;
    for (int i = 2; i <= 5; i++) pop_a(3'(i));
    repeat (3) @(posedge clk) #1;
    check("drained count", a_count, 0);

    // Reset while a request is outstanding
    push_a(3'b111);
    for (int k = 0; k < 100 && a_req_out !== 1'b1; k++) @(posedge clk) #1;
    check("pre-reset data", a_dout, 3'b111);
    #3 rst = 1'b1;
    #1;
    check("async reset req_out", a_req_out, 0);
    check("async reset ack_in", a_ack_in, 0);
    check("async reset count", a_count, 0);
    check("async reset data_out", a_dout, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    push_a(3'b001);
    pop_a(3'b001);
    repeat (2) @(posedge clk) #1;
    check("post-reset count", a_count, 0);

    // Wrap-around on DEPTH=3 with random consumer delays
    b_max = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_b(4'(i + 3));
      end
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 6)) @(posedge clk) #1;
          pop_b(4'(i + 3));
        end
      end
    join
    repeat (3) @(posedge clk) #1;
    check("wrap count bound", (b_max <= 3), 1);
    check("wrap final count", b_count, 0);

    // Two-phase with 2-flop synchronisers
    c_din = 3'b011;
    c_req = 1'b1;
    repeat (2) @(posedge clk) #1;
    check("2ph ack before latency", c_ack_in, 0);
    @(posedge clk) #1;
    check("2ph ack toggle word1", c_ack_in, 1);
    check("2ph count word1", c_count, 1);
    check("2ph req_out not yet", c_req_out, 0);
    @(posedge clk) #1;
    check("2ph req_out toggle word1", c_req_out, 1);
    check("2ph data word1", c_dout, 3'b011);
    c_din = 3'b110;
    c_req = 1'b0;
    repeat (2) @(posedge clk) #1;
    check("2ph ack held word2", c_ack_in, 1);
    @(posedge clk) #1;
    check("2ph ack toggle word2", c_ack_in, 0);
    check("2ph count word2", c_count, 2);
    c_ack_out = 1'b1;
    repeat (2) @(posedge clk) #1;
    check("2ph no pop before latency", c_count, 2);
    @(posedge clk) #1;
    check("2ph pop word1 count", c_count, 1);
    check("2ph data held after pop", c_dout, 3'b011);
    @(posedge clk) #1;
    check("2ph req_out toggle word2", c_req_out, 0);
    check("2ph data word2", c_dout, 3'b110);
    c_ack_out = 1'b0;
    repeat (3) @(posedge clk) #1;
    check("2ph pop word2 count", c_count, 0);
    check("2ph req_out idle", c_req_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
